// File: rtl/pc_unit_vec.sv
// pc_unit_vec: program counter with sequential/branch/JALR selection and vectored edge-triggered interrupts.
// Define IRQ_MASK_EN to add the irq_mask input (1 = line enabled).
module pc_unit_vec #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IRQ = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [ADDRESS_WIDTH-1:0] IRQ_BASE = 32'h0000_0100,
    parameter int IRQ_STRIDE = 16,
    localparam int IW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic [1:0]               pc_src,
    input  logic [DATA_WIDTH-1:0]    imm_ext,
    input  logic [DATA_WIDTH-1:0]    jalr_target,
    input  logic                     mret,
    input  logic [NUM_IRQ-1:0]       irq,
`ifdef IRQ_MASK_EN
    input  logic [NUM_IRQ-1:0]       irq_mask,
`endif
    output logic [ADDRESS_WIDTH-1:0] pc_out,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4,
    output logic [ADDRESS_WIDTH-1:0] epc_out,
    output logic                     irq_active,
    output logic [IW-1:0]            irq_id
);
    typedef enum logic {IDLE, ISR} state_t;
    state_t state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d, epc_q, epc_d, seq_next;
    logic [NUM_IRQ-1:0] irq_q, pend_q, pend_d, elig, clr;
    logic [IW-1:0] id_q, id_d, k;
    logic take;
    logic unused;
    assign unused = ^{imm_ext, jalr_target};
`ifdef IRQ_MASK_EN
    assign elig = pend_q & irq_mask;
`else
    assign elig = pend_q;
`endif
    assign pc_plus4 = pc_q + ADDRESS_WIDTH'(4);
    assign seq_next = pc_src == 2'b01 ? pc_q + ADDRESS_WIDTH'(imm_ext) :
                      pc_src == 2'b10 ? ADDRESS_WIDTH'(jalr_target) & ~ADDRESS_WIDTH'(1) : pc_plus4;
    // Descending scan so the lowest eligible index is the one left in k.
    always_comb begin
        take = 1'b0;
        k = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                take = 1'b1;
                k = IW'(i);
            end
        end
    end
    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        epc_d = epc_q;
        id_d = id_q;
        clr = '0;
        if (!stall) begin
            if (state_q == ISR) begin
                pc_d = mret ? epc_q : seq_next;
                state_d = mret ? IDLE : ISR;
            end else if (take) begin
                epc_d = seq_next;
                pc_d = IRQ_BASE + ADDRESS_WIDTH'(IRQ_STRIDE) * ADDRESS_WIDTH'(k);
                id_d = k;
                clr = NUM_IRQ'(1) << k;
                state_d = ISR;
            end else begin
                pc_d = seq_next;
            end
        end
        pend_d = (pend_q & ~clr) | (irq & ~irq_q);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q <= RESET_VECTOR;
            epc_q <= '0;
            id_q <= '0;
            pend_q <= '0;
            irq_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            epc_q <= epc_d;
            id_q <= id_d;
            pend_q <= pend_d;
            irq_q <= irq;
        end
    end
    assign pc_out = pc_q;
    assign epc_out = epc_q;
    assign irq_active = state_q == ISR;
    assign irq_id = id_q;
endmodule

// File: tb/tb_pc_unit_vec.sv
// tb_pc_unit_vec: directed scenarios plus randomized cycles against a procedural reference model.
module tb_pc_unit_vec;
    logic clk = 1'b0;
    logic rst, stall, mret;
    logic [1:0] pc_src;
    logic [31:0] imm_ext, jalr_target;
    logic [3:0] irq;
`ifdef IRQ_MASK_EN
    logic [3:0] irq_mask;
`endif
    logic [31:0] pc_out, pc_plus4, epc_out;
    logic irq_active;
    logic [1:0] irq_id;
    int tests = 0, fails = 0;
    logic [31:0] m_pc, m_epc;
    logic [3:0] m_pend, m_prev;
    logic m_isr;
    logic [1:0] m_id;

    pc_unit_vec dut (
        .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src), .imm_ext(imm_ext),
        .jalr_target(jalr_target), .mret(mret), .irq(irq),
`ifdef IRQ_MASK_EN
        .irq_mask(irq_mask),
`endif
        .pc_out(pc_out), .pc_plus4(pc_plus4), .epc_out(epc_out),
        .irq_active(irq_active), .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    // Advances the reference model by one clock using the inputs currently driven, then waits past the edge.
    task automatic tick();
        logic [31:0] seq;
        logic [3:0] en;
        int k;
        seq = pc_src == 2'b01 ? m_pc + imm_ext : pc_src == 2'b10 ? {jalr_target[31:1], 1'b0} : m_pc + 32'd4;
        en = m_pend;
`ifdef IRQ_MASK_EN
        en = en & irq_mask;
`endif
        k = -1;
        for (int i = 3; i >= 0; i--) if (en[i]) k = i;
        if (rst) begin
            m_pc = 32'h0; m_epc = 32'h0; m_pend = 4'h0; m_prev = 4'h0; m_isr = 1'b0; m_id = 2'd0;
        end else begin
            if (!stall) begin
                if (m_isr) begin
                    if (mret) begin m_pc = m_epc; m_isr = 1'b0; end
                    else m_pc = seq;
                end else if (k >= 0) begin
                    m_epc = seq;
                    m_pc = 32'h100 + 32'(16 * k);
                    m_id = 2'(k);
                    m_pend[k] = 1'b0;
                    m_isr = 1'b1;
                end else m_pc = seq;
            end
            m_pend = m_pend | (irq & ~m_prev);
            m_prev = irq;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; stall = 1'b0; mret = 1'b0; pc_src = 2'b00; imm_ext = '0; jalr_target = '0; irq = '0;
`ifdef IRQ_MASK_EN
        irq_mask = 4'hF;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp %h", pc_out, 32'h0); end
        tests++; if (epc_out !== 32'h0) begin fails++; $display("FAIL reset_epc got %h exp %h", epc_out, 32'h0); end
        tests++; if (irq_active !== 1'b0) begin fails++; $display("FAIL reset_active got %b exp 0", irq_active); end
        tests++; if (irq_id !== 2'd0) begin fails++; $display("FAIL reset_id got %0d exp 0", irq_id); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            tests++; if (pc_out !== 32'(4 * i)) begin fails++; $display("FAIL seq_pc got %h exp %h", pc_out, 32'(4 * i)); end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL midreset_pc got %h exp 0", pc_out); end
    endtask

    task automatic test_branch();
        do_reset();
        repeat (4) tick();
        pc_src = 2'b01; imm_ext = -32'sd8;
        tick();
        tests++; if (pc_out !== 32'h8) begin fails++; $display("FAIL branch_back got %h exp 8", pc_out); end
        pc_src = 2'b10; jalr_target = 32'h0000_0123;
        tick();
        tests++; if (pc_out !== 32'h122) begin fails++; $display("FAIL jalr_lsb got %h exp 122", pc_out); end
        tests++; if (pc_plus4 !== 32'h126) begin fails++; $display("FAIL pc_plus4 got %h exp 126", pc_plus4); end
        jalr_target = 32'hFFFF_FFFC;
        tick();
        pc_src = 2'b00;
        tick();
        tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL wrap got %h exp 0", pc_out); end
        pc_src = 2'b11;
        tick();
        tests++; if (pc_out !== 32'h4) begin fails++; $display("FAIL src11 got %h exp 4", pc_out); end
    endtask

    task automatic test_irq_branch();
        do_reset();
        pc_src = 2'b10; jalr_target = 32'h20;
        tick();
        pc_src = 2'b01; imm_ext = 32'h40; irq = 4'b0100;
        tick();
        tests++; if (pc_out !== 32'h60) begin fails++; $display("FAIL irq_edge_pc got %h exp 60", pc_out); end
        tick();
        tests++; if (pc_out !== 32'h120) begin fails++; $display("FAIL irq_vec got %h exp 120", pc_out); end
        tests++; if (epc_out !== 32'hA0) begin fails++; $display("FAIL irq_epc got %h exp a0", epc_out); end
        tests++; if (irq_active !== 1'b1 || irq_id !== 2'd2) begin fails++; $display("FAIL irq_state got %b/%0d exp 1/2", irq_active, irq_id); end
        pc_src = 2'b00; mret = 1'b1;
        tick();
        mret = 1'b0; irq = 4'b0000;
        tests++; if (pc_out !== 32'hA0 || irq_active !== 1'b0) begin fails++; $display("FAIL mret_ret got %h/%b exp a0/0", pc_out, irq_active); end
    endtask

    task automatic test_priority();
        do_reset();
        tick();
        irq = 4'b1010;
        tick();
        tick();
        tests++; if (pc_out !== 32'h110 || irq_id !== 2'd1) begin fails++; $display("FAIL prio_first got %h/%0d exp 110/1", pc_out, irq_id); end
        tests++; if (epc_out !== 32'hC) begin fails++; $display("FAIL prio_epc got %h exp c", epc_out); end
        mret = 1'b1;
        tick();
        mret = 1'b0;
        tests++; if (pc_out !== 32'hC || irq_active !== 1'b0) begin fails++; $display("FAIL prio_ret got %h/%b exp c/0", pc_out, irq_active); end
        tick();
        tests++; if (pc_out !== 32'h130 || irq_id !== 2'd3 || irq_active !== 1'b1) begin fails++; $display("FAIL prio_second got %h/%0d/%b exp 130/3/1", pc_out, irq_id, irq_active); end
        tests++; if (epc_out !== 32'h10) begin fails++; $display("FAIL prio_epc2 got %h exp 10", epc_out); end
        irq = 4'b0000;
    endtask

    task automatic test_stall_nesting();
        do_reset();
        tick();
        stall = 1'b1; irq = 4'b0001;
        repeat (3) begin
            tick();
            tests++; if (pc_out !== 32'h4 || irq_active !== 1'b0) begin fails++; $display("FAIL stall_hold got %h/%b exp 4/0", pc_out, irq_active); end
        end
        stall = 1'b0;
        tick();
        tests++; if (pc_out !== 32'h100 || epc_out !== 32'h8) begin fails++; $display("FAIL stall_take got %h/%h exp 100/8", pc_out, epc_out); end
        irq = 4'b0000;
        tick();
        irq = 4'b0010;
        tick();
        tick();
        tests++; if (pc_out !== 32'h10C || irq_id !== 2'd0 || irq_active !== 1'b1) begin fails++; $display("FAIL no_nest got %h/%0d/%b exp 10c/0/1", pc_out, irq_id, irq_active); end
        mret = 1'b1;
        tick();
        tests++; if (pc_out !== 32'h8) begin fails++; $display("FAIL nest_ret got %h exp 8", pc_out); end
        mret = 1'b0;
        tick();
        tests++; if (pc_out !== 32'h110 || irq_id !== 2'd1) begin fails++; $display("FAIL nest_take got %h/%0d exp 110/1", pc_out, irq_id); end
        mret = 1'b1;
        tick();
        tick();
        mret = 1'b0;
        tests++; if (pc_out !== 32'h10 || irq_active !== 1'b0) begin fails++; $display("FAIL mret_idle got %h/%b exp 10/0", pc_out, irq_active); end
        irq = 4'b0000;
    endtask

`ifdef IRQ_MASK_EN
    task automatic test_mask();
        do_reset();
        irq_mask = 4'b1101; irq = 4'b0010;
        repeat (3) tick();
        tests++; if (irq_active !== 1'b0) begin fails++; $display("FAIL mask_block got %b exp 0", irq_active); end
        irq_mask = 4'b1111;
        tick();
        tests++; if (pc_out !== 32'h110 || irq_active !== 1'b1) begin fails++; $display("FAIL mask_release got %h/%b exp 110/1", pc_out, irq_active); end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = $urandom_range(0, 59) == 0;
            stall = $urandom_range(0, 4) == 0;
            mret = $urandom_range(0, 5) == 0;
            pc_src = 2'($urandom);
            imm_ext = $urandom;
            jalr_target = $urandom;
            if ($urandom_range(0, 2) == 0) irq = irq ^ 4'($urandom);
`ifdef IRQ_MASK_EN
            if ($urandom_range(0, 3) == 0) irq_mask = 4'($urandom);
`endif
            tick();
            tests++; if (pc_out !== m_pc) begin fails++; $display("FAIL rnd_pc cyc %0d got %h exp %h", c, pc_out, m_pc); end
            tests++; if (pc_plus4 !== m_pc + 32'd4) begin fails++; $display("FAIL rnd_plus4 cyc %0d got %h exp %h", c, pc_plus4, m_pc + 32'd4); end
            tests++; if (epc_out !== m_epc) begin fails++; $display("FAIL rnd_epc cyc %0d got %h exp %h", c, epc_out, m_epc); end
            tests++; if (irq_active !== m_isr) begin fails++; $display("FAIL rnd_active cyc %0d got %b exp %b", c, irq_active, m_isr); end
            tests++; if (irq_id !== m_id) begin fails++; $display("FAIL rnd_id cyc %0d got %0d exp %0d", c, irq_id, m_id); end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_irq_branch();
        test_priority();
        test_stall_nesting();
`ifdef IRQ_MASK_EN
        test_mask();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
